// File: rtl/fox_net_pkg.sv
// Register map, STATUS bit positions and packet field placement for the fox network interface.
package fox_net_pkg;

    localparam logic [6:0] OFS_TX_X       = 7'h00;
    localparam logic [6:0] OFS_TX_Y       = 7'h04;
    localparam logic [6:0] OFS_TX_MCAST   = 7'h08;
    localparam logic [6:0] OFS_TX_FLAGS   = 7'h0C;
    localparam logic [6:0] OFS_TX_MTYPE   = 7'h10;
    localparam logic [6:0] OFS_TX_MX      = 7'h14;
    localparam logic [6:0] OFS_TX_MY      = 7'h18;
    localparam logic [6:0] OFS_TX_ELEM    = 7'h1C;
    localparam logic [6:0] OFS_TX_COMMIT  = 7'h20;
    localparam logic [6:0] OFS_STATUS     = 7'h24;
    localparam logic [6:0] OFS_RX_MCAST   = 7'h28;
    localparam logic [6:0] OFS_RX_FLAGS   = 7'h2C;
    localparam logic [6:0] OFS_RX_MTYPE   = 7'h30;
    localparam logic [6:0] OFS_RX_MX      = 7'h34;
    localparam logic [6:0] OFS_RX_MY      = 7'h38;
    localparam logic [6:0] OFS_RX_ELEM    = 7'h3C;
    localparam logic [6:0] OFS_RX_POP     = 7'h40;
    localparam logic [6:0] OFS_STATUS_CLR = 7'h44;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_UNF   = 3;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    // Field LSB positions, element field at bit 0.
    function automatic int pos_my(int e);
        return e;
    endfunction
    function automatic int pos_mx(int e, int mc);
        return e + mc;
    endfunction
    function automatic int pos_mtype(int e, int mc);
        return e + 2*mc;
    endfunction
    function automatic int pos_result(int e, int mc, int mt);
        return e + 2*mc + mt;
    endfunction
    function automatic int pos_done(int e, int mc, int mt);
        return e + 2*mc + mt + 1;
    endfunction
    function automatic int pos_mcast(int e, int mc, int mt);
        return e + 2*mc + mt + 2;
    endfunction
    function automatic int pkt_width(int c, int g, int mt, int mc, int e);
        return 2*c + g + 2 + mt + 2*mc + e;
    endfunction

endpackage

// File: rtl/fox_net_if_sync_fifo.sv
// Power-of-two synchronous FIFO; a push into a full FIFO lands when a pop frees the slot that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fox_net_if.sv
// CPU register front-end for the fox network: stages and commits TX packets, exposes and pops RX packets.
module fox_net_if
    import fox_net_pkg::*;
#(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int TX_DEPTH             = 4,
    parameter int RX_DEPTH             = 4,
    localparam int PKT_W = pkt_width(COORD_BITS, MULTICAST_GROUP_BITS, MATRIX_TYPE_BITS,
                                     MATRIX_COORD_BITS, MATRIX_ELEMENT_BITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bus_valid,
    input  logic             bus_write,
    input  logic [6:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ready,
    output logic [PKT_W-1:0] pkt_out,
    output logic             pkt_out_valid,
    input  logic             pkt_out_ready,
    input  logic [PKT_W-1:0] pkt_in,
    input  logic             pkt_in_valid,
    output logic             pkt_in_ready,
    output logic             irq_rx
);

    localparam int C  = COORD_BITS;
    localparam int G  = MULTICAST_GROUP_BITS;
    localparam int MT = MATRIX_TYPE_BITS;
    localparam int MC = MATRIX_COORD_BITS;
    localparam int E  = MATRIX_ELEMENT_BITS;
    localparam int P_MY = pos_my(E);
    localparam int P_MX = pos_mx(E, MC);
    localparam int P_MT = pos_mtype(E, MC);
    localparam int P_RS = pos_result(E, MC, MT);
    localparam int P_DN = pos_done(E, MC, MT);
    localparam int P_MG = pos_mcast(E, MC, MT);

    logic [C-1:0]  tx_x_q, tx_y_q;
    logic [G-1:0]  tx_mcast_q;
    logic          tx_done_q, tx_res_q;
    logic [MT-1:0] tx_mtype_q;
    logic [MC-1:0] tx_mx_q, tx_my_q;
    logic [E-1:0]  tx_elem_q;
    logic          ovf_q, unf_q, bus_ready_q;
    logic [31:0]   bus_rdata_q, rdata_d, status_d;

    logic [PKT_W-1:0] tx_pkt, rx_head, rx_hd;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [$clog2(TX_DEPTH):0] tx_cnt;
    logic [$clog2(RX_DEPTH):0] rx_cnt;

    // An access is taken only when no completion is showing, so bus_ready never repeats back to back.
    logic acc, wr_acc, commit, tx_pop, rx_pop_req, status_clr, rx_push;
    assign acc        = bus_valid && !bus_ready_q;
    assign wr_acc     = acc && bus_write;
    assign commit     = wr_acc && (bus_addr == OFS_TX_COMMIT);
    assign rx_pop_req = wr_acc && (bus_addr == OFS_RX_POP);
    assign status_clr = wr_acc && (bus_addr == OFS_STATUS_CLR);
    assign tx_pop     = pkt_out_ready && !tx_empty;
    assign rx_push    = pkt_in_valid && pkt_in_ready;

    assign tx_pkt = {tx_x_q, tx_y_q, tx_mcast_q, tx_done_q, tx_res_q, tx_mtype_q,
                     tx_mx_q, tx_my_q, tx_elem_q};

    sync_fifo #(.WIDTH(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(commit), .data_i(tx_pkt), .pop_i(tx_pop),
        .data_o(pkt_out), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt));

    sync_fifo #(.WIDTH(PKT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(rx_push), .data_i(pkt_in), .pop_i(rx_pop_req),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt));

    assign pkt_out_valid = !tx_empty;
    assign pkt_in_ready  = reset_n && !rx_full;
    assign irq_rx        = !rx_empty;
    assign bus_ready     = bus_ready_q;
    assign bus_rdata     = bus_rdata_q;
    assign rx_hd         = rx_empty ? '0 : rx_head;

    always_comb begin
        status_d = '0;
        status_d[ST_TX_FULL]       = tx_full;
        status_d[ST_RX_EMPTY]      = rx_empty;
        status_d[ST_TX_OVF]        = ovf_q;
        status_d[ST_RX_UNF]        = unf_q;
        status_d[ST_TX_CNT +: 8]   = 8'(tx_cnt);
        status_d[ST_RX_CNT +: 8]   = 8'(rx_cnt);
    end

    always_comb begin
        rdata_d = '0;
        case (bus_addr)
            OFS_TX_X:     rdata_d = 32'(tx_x_q);
            OFS_TX_Y:     rdata_d = 32'(tx_y_q);
            OFS_TX_MCAST: rdata_d = 32'(tx_mcast_q);
            OFS_TX_FLAGS: rdata_d = {30'd0, tx_res_q, tx_done_q};
            OFS_TX_MTYPE: rdata_d = 32'(tx_mtype_q);
            OFS_TX_MX:    rdata_d = 32'(tx_mx_q);
            OFS_TX_MY:    rdata_d = 32'(tx_my_q);
            OFS_TX_ELEM:  rdata_d = 32'(tx_elem_q);
            OFS_STATUS:   rdata_d = status_d;
            OFS_RX_MCAST: rdata_d = 32'(rx_hd[P_MG +: G]);
            OFS_RX_FLAGS: rdata_d = {30'd0, rx_hd[P_RS], rx_hd[P_DN]};
            OFS_RX_MTYPE: rdata_d = 32'(rx_hd[P_MT +: MT]);
            OFS_RX_MX:    rdata_d = 32'(rx_hd[P_MX +: MC]);
            OFS_RX_MY:    rdata_d = 32'(rx_hd[P_MY +: MC]);
            OFS_RX_ELEM:  rdata_d = 32'(rx_hd[0 +: E]);
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_x_q <= '0; tx_y_q <= '0; tx_mcast_q <= '0; tx_done_q <= 1'b0; tx_res_q <= 1'b0;
            tx_mtype_q <= '0; tx_mx_q <= '0; tx_my_q <= '0; tx_elem_q <= '0;
        end else if (wr_acc) begin
            case (bus_addr)
                OFS_TX_X:     tx_x_q     <= bus_wdata[C-1:0];
                OFS_TX_Y:     tx_y_q     <= bus_wdata[C-1:0];
                OFS_TX_MCAST: tx_mcast_q <= bus_wdata[G-1:0];
                OFS_TX_FLAGS: begin
                    tx_done_q <= bus_wdata[0];
                    tx_res_q  <= bus_wdata[1];
                end
                OFS_TX_MTYPE: tx_mtype_q <= bus_wdata[MT-1:0];
                OFS_TX_MX:    tx_mx_q    <= bus_wdata[MC-1:0];
                OFS_TX_MY:    tx_my_q    <= bus_wdata[MC-1:0];
                OFS_TX_ELEM:  tx_elem_q  <= bus_wdata[E-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            bus_ready_q <= 1'b0;
            bus_rdata_q <= '0;
        end else begin
            ovf_q <= (ovf_q && !(status_clr && bus_wdata[ST_TX_OVF])) ||
                     (commit && tx_full && !tx_pop);
            unf_q <= (unf_q && !(status_clr && bus_wdata[ST_RX_UNF])) ||
                     (rx_pop_req && rx_empty);
            bus_ready_q <= acc;
            bus_rdata_q <= (acc && !bus_write) ? rdata_d : '0;
        end
    end

endmodule
